// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell, the datapath element of the serial adder.
module one_bit_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, one bit per clock LSB first, valid/ready on both sides.
// Optional unsigned saturation on completion when SERIAL_ADDER_SAT_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
`ifdef SERIAL_ADDER_SAT_EN
  logic             mode_q, mode_d;
`endif

  logic fa_s;
  logic fa_c;
  logic last_bit;

  one_bit_full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SAT_EN
      mode_q  <= MODE_ADD;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ADDER_SAT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SAT_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
          a_d     = a;
          b_d     = (mode == MODE_SUB) ? ~b : b;
          carry_d = mode;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SAT_EN
          mode_d  = mode;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          c_out_d = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
`ifdef SERIAL_ADDER_SAT_EN
          if ((mode_q == MODE_ADD) && fa_c) begin
            sum_d = '1;
          end else if ((mode_q == MODE_SUB) && !fa_c) begin
            sum_d = '0;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, corner sequences, randomized scoreboard.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int NRAND = 1300;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] sat_adj(input logic m, input logic c, input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
`ifdef SERIAL_ADDER_SAT_EN
    if (!m && c) r = '1;
    else if (m && !c) r = '0;
`else
    if (m && c) r = s;
`endif
    return r;
  endfunction

  // Integer arithmetic reference: returns {overflow, c_out, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic m);
    int ux, uy, sx, sy, ur, sr;
    logic c, ov;
    logic [WIDTH-1:0] s;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!m) begin
      ur = ux + uy;
      sr = sx + sy;
      c  = (ur >= (1 << WIDTH));
    end else begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end
    s  = ur[WIDTH-1:0];
    ov = (sr > ((1 << (WIDTH - 1)) - 1)) || (sr < -(1 << (WIDTH - 1)));
    return {ov, c, sat_adj(m, c, s)};
  endfunction

  // Called at a negedge; returns result and cycles from handshake edge to out_valid.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv, input logic tm,
                         output logic [WIDTH-1:0] rs, output logic rc, output logic rov,
                         output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("txn_in_ready_before", in_ready, 1);
    a = ta;
    b = tbv;
    mode = tm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * WIDTH) begin
      @(negedge clk);
      lat++;
    end
    rs  = sum;
    rc  = c_out;
    rov = overflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("txn_in_ready_after", in_ready, 1);
    chk("txn_out_valid_after", out_valid, 0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [WIDTH-1:0] rs;
    logic             rc, rov;
    int               lat;
    logic [WIDTH+1:0] held, expv;
    logic [WIDTH+1:0] q[$];
    int               cyc, done_cnt, busy, acc_time;
    logic             seen_v, prev_p1, phase1;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    mode = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_c_out", c_out, 0);
    chk("reset_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].a, tbl[i].b, tbl[i].m, rs, rc, rov, lat);
      chk($sformatf("vec%0d_latency", i), lat, WIDTH);
      chk($sformatf("vec%0d_sum", i), rs, sat_adj(tbl[i].m, tbl[i].c, tbl[i].s));
      chk($sformatf("vec%0d_c_out", i), rc, tbl[i].c);
      chk($sformatf("vec%0d_overflow", i), rov, tbl[i].ov);
    end

    // Back-pressure: hold result, offer new operands while busy.
    a = 8'h21;
    b = 8'h12;
    mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * WIDTH) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, WIDTH);
    held = {overflow, c_out, sum};
    chk("bp_result", held, model(8'h21, 8'h12, 1'b0));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      mode = 1'($urandom);
      @(negedge clk);
      chk("bp_stable", {overflow, c_out, sum}, held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(negedge clk);
    chk("bp_no_phantom_start", in_ready, 1);

    // Reset in the third RUN cycle.
    a = 8'h77;
    b = 8'h11;
    mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outputs", {overflow, c_out, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(8'h01, 8'h01, 1'b0, rs, rc, rov, lat);
    chk("midrst_next_latency", lat, WIDTH);
    chk("midrst_next_sum", rs, 8'h02);
    chk("midrst_next_flags", {rov, rc}, 2'b00);

    // Randomized scoreboard: back-to-back with out_ready tied high, then random handshakes.
    cyc = 0;
    done_cnt = 0;
    busy = 0;
    acc_time = 0;
    seen_v = 1'b0;
    prev_p1 = 1'b0;
    while (done_cnt < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      phase1 = (done_cnt < 1000);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      mode = 1'($urandom);
      in_valid = phase1 ? 1'b1 : 1'($urandom);
      out_ready = phase1 ? 1'b1 : 1'($urandom);
      if (out_valid && !seen_v) begin
        seen_v = 1'b1;
        chk("rand_latency", cyc - acc_time, WIDTH);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 1, 0);
        end else begin
          expv = q.pop_front();
          chk("rand_result", {overflow, c_out, sum}, expv);
        end
        done_cnt++;
        seen_v = 1'b0;
      end
      if (!in_ready) busy++;
      if (in_valid && in_ready) begin
        if (phase1 && prev_p1) chk("b2b_busy_cycles", busy, WIDTH + 1);
        busy = 0;
        prev_p1 = phase1;
        q.push_back(model(a, b, mode));
        acc_time = cyc + 1;
      end
    end
    chk("rand_complete", done_cnt, NRAND);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; processes one bit per clock, LSB first.
- Reuses the team's single-bit full adder cell as the datapath element.
- Computes WIDTH-bit a+b or a-b with carry-out and signed-overflow flags.
- Valid/ready handshake on both input and output, for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block idle, will accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b).
- out_valid  output  1  result valid, held until accepted.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB; in subtract mode, 1 means no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum, c_out, overflow, all shift registers, counter and carry all = 0.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, in_valid=1 at an edge:
  - latch a, and b (b inverted when mode=1).
  - carry reg <= mode; counter <= 0; state -> RUN.
- RUN, each cycle:
  - full adder takes operand LSBs plus the carry register.
  - sum bit shifts into the result register from the MSB side; operand registers shift right.
  - carry register updates; counter increments.
- RUN, on counter==WIDTH-1:
  - capture c_out = full-adder carry.
  - overflow = carry-in of that bit XOR its carry-out.
  - state -> DONE.
- Latency: out_valid rises exactly WIDTH cycles after the input handshake edge.
- DONE:
  - sum/c_out/overflow held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge -> IDLE; in_ready=1 the following cycle.
  - No back-to-back overlap: minimum initiation interval is WIDTH+1 cycles.
- in_valid while not IDLE: ignored; operands not captured.
- out_ready while not DONE: ignored.
- Arithmetic is modulo 2^WIDTH; sum is undriven by combinational paths (registered outputs only).
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; no partial result is ever presented.
- mode is sampled only at the input handshake; later changes have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SAT_EN.
- Defined: unsigned saturation applied when entering DONE.
  - add with c_out=1 -> sum = all ones.
  - subtract with c_out=0 (borrow) -> sum = 0.
  - c_out and overflow still report raw values.
- Undefined: wrap-around result only; no saturation logic synthesised.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE).
  - MODE_ADD=1'b0, MODE_SUB=1'b1 constants.
- Sub-module: one_bit_full_adder instantiated once as the serial datapath cell.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, add 0x5A+0x3C -> after 8 cycles out_valid=1, sum=0x96, c_out=0, overflow=1.
- Add 0xFF+0x01 -> sum=0x00, c_out=1, overflow=0; with SERIAL_ADDER_SAT_EN, sum=0xFF.
- Subtract 0x10-0x20 -> sum=0xF0, c_out=0, overflow=0; with SERIAL_ADDER_SAT_EN, sum=0x00.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands.
  - Expect outputs stable, in_ready=0, new operands ignored.
  - After out_ready=1 handshake, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 in the 3rd RUN cycle.
  - Expect all outputs zero and in_ready=1 immediately.
  - A new 0x01+0x01 then yields sum=0x02 with correct latency.
- Back-to-back: two transactions with out_ready tied 1.
  - Expect the second accepted WIDTH+1 cycles after the first.
  - Both results correct, verified against the golden model over 1000 random operand/mode sets.
